// File: rtl/lsu_seq.sv
// Load/store unit sequencer: accepts one memory request at a time, drives a
// single-beat data bus access and returns load data or an exception pulse.
package lsu_seq_pkg;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LB  = 4'h1,
        OP_LH  = 4'h2,
        OP_LW  = 4'h3,
        OP_LBU = 4'h4,
        OP_LHU = 4'h5,
        OP_SB  = 4'h6,
        OP_SH  = 4'h7,
        OP_SW  = 4'h8,
        OP_ALU = 4'h9
    } lsu_op_t;
endpackage

module lsu_seq
    import lsu_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  lsu_op_t         req_op_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            endianness_i,
    output logic            resp_valid_o,
    output logic            dest_en_o,
    output logic [XLEN-1:0] dest_data_o,
    output logic            misaligned_o,
    output logic            access_fault_o,
    output logic            dbus_rd_en_o,
    output logic            dbus_wr_en_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wr_data_o,
    output logic [XLEN/8-1:0] dbus_wr_strobe_o,
    input  logic [XLEN-1:0] dbus_rd_data_i,
    input  logic            dbus_wait_i,
    input  logic            dbus_err_i
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic logic isLoad(input lsu_op_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic isStore(input lsu_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_t opSize(input lsu_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic isMisaligned(input lsu_op_t op, input logic [1:0] a);
        case (opSize(op))
            SZ_H:    return a[0];
            SZ_W:    return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    state_t          state_q, state_d;
    lsu_op_t         op_q, op_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            bigEnd_q, bigEnd_d;
    logic [7:0]      waitCnt_q, waitCnt_d;
    logic            misal_q, misal_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [OFFW-1:0] off;
    logic [OFFW+2:0] shAmt;
    logic [XLEN-1:0] rdShifted;
    logic [7:0]      ldByte;
    logic [15:0]     ldHalf;
    logic [31:0]     ldWord;
    logic            ldSigned;
    logic [XLEN-1:0] loadVal;
    logic [31:0]     stOpnd;
    logic [NB-1:0]   strbBase;
    logic            inAccess;

    assign off   = addr_q[OFFW-1:0];
    assign shAmt = {off, 3'b000};

    // Load path: move the addressed lane down, undo big-endian order, extend.
    always_comb begin
        rdShifted = dbus_rd_data_i >> shAmt;
        ldByte    = rdShifted[7:0];
        ldHalf    = bigEnd_q ? {rdShifted[7:0], rdShifted[15:8]} : rdShifted[15:0];
        ldWord    = bigEnd_q ? {rdShifted[7:0], rdShifted[15:8], rdShifted[23:16], rdShifted[31:24]}
                             : rdShifted[31:0];
        ldSigned  = (op_q == OP_LB) || (op_q == OP_LH);
        case (opSize(op_q))
            SZ_B:    loadVal = {{(XLEN-8){ldSigned & ldByte[7]}}, ldByte};
            SZ_H:    loadVal = {{(XLEN-16){ldSigned & ldHalf[15]}}, ldHalf};
            default: loadVal = XLEN'(ldWord);
        endcase
    end

    always_comb begin
        stOpnd   = '0;
        strbBase = '0;
        case (opSize(op_q))
            SZ_B: begin
                stOpnd   = {24'b0, wdata_q[7:0]};
                strbBase = NB'(1);
            end
            SZ_H: begin
                stOpnd   = bigEnd_q ? {16'b0, wdata_q[7:0], wdata_q[15:8]} : {16'b0, wdata_q[15:0]};
                strbBase = NB'(3);
            end
            default: begin
                stOpnd   = bigEnd_q ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]}
                                    : wdata_q;
                strbBase = NB'(15);
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bigEnd_d  = bigEnd_q;
        waitCnt_d = waitCnt_q;
        misal_d   = misal_q;
        fault_d   = fault_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && (isLoad(req_op_i) || isStore(req_op_i))) begin
                    op_d      = req_op_i;
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i[31:0];
                    bigEnd_d  = endianness_i;
                    waitCnt_d = '0;
                    fault_d   = 1'b0;
                    rdata_d   = '0;
                    misal_d   = isMisaligned(req_op_i, req_addr_i[1:0]);
                    state_d   = misal_d ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // Bus error wins over wait; a stalled bus is abandoned at TIMEOUT.
                if (dbus_err_i) begin
                    fault_d = 1'b1;
                    state_d = RESP;
                end else if (!dbus_wait_i) begin
                    state_d = RESP;
                    if (isLoad(op_q)) rdata_d = loadVal;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                    if (waitCnt_d == 8'(TIMEOUT)) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= OP_NOP;
            addr_q    <= '0;
            wdata_q   <= '0;
            bigEnd_q  <= 1'b0;
            waitCnt_q <= '0;
            misal_q   <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bigEnd_q  <= bigEnd_d;
            waitCnt_q <= waitCnt_d;
            misal_q   <= misal_d;
            fault_q   <= fault_d;
            rdata_q   <= rdata_d;
        end
    end

    assign inAccess         = (state_q == ACCESS);
    assign req_ready_o      = (state_q == IDLE);
    assign dbus_rd_en_o     = inAccess && isLoad(op_q);
    assign dbus_wr_en_o     = inAccess && isStore(op_q);
    assign dbus_addr_o      = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign dbus_wr_data_o   = dbus_wr_en_o ? (XLEN'(stOpnd) << shAmt) : '0;
    assign dbus_wr_strobe_o = dbus_wr_en_o ? (strbBase << off) : '0;
    assign resp_valid_o     = (state_q == RESP);
    assign misaligned_o     = resp_valid_o && misal_q;
    assign access_fault_o   = resp_valid_o && fault_q;
    assign dest_en_o        = resp_valid_o && isLoad(op_q) && !misal_q && !fault_q;
    assign dest_data_o      = dest_en_o ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: each task drives one scenario and checks the
// expected bus and response values cycle by cycle.
module tb_lsu_seq;
    import lsu_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    lsu_op_t     reqOp;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        endianness;
    logic        respValid;
    logic        destEn;
    logic [31:0] destData;
    logic        misaligned;
    logic        accessFault;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] busAddr;
    logic [31:0] wrData;
    logic [3:0]  wrStrobe;
    logic [31:0] rdData;
    logic        busWait;
    logic        busErr;

    int checks = 0;
    int errors = 0;

    lsu_seq #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_op_i(reqOp),
        .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .endianness_i(endianness),
        .resp_valid_o(respValid), .dest_en_o(destEn), .dest_data_o(destData),
        .misaligned_o(misaligned), .access_fault_o(accessFault),
        .dbus_rd_en_o(rdEn), .dbus_wr_en_o(wrEn), .dbus_addr_o(busAddr),
        .dbus_wr_data_o(wrData), .dbus_wr_strobe_o(wrStrobe),
        .dbus_rd_data_i(rdData), .dbus_wait_i(busWait), .dbus_err_i(busErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the request inputs so that
    // anything not registered at accept shows up as wrong data.
    task automatic issue(input lsu_op_t op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic be);
        reqValid = 1'b1; reqOp = op; reqAddr = addr; reqWdata = wdata; endianness = be;
        tick();
        reqValid = 1'b0; reqOp = OP_NOP; reqAddr = 32'hFFFF_FFFC;
        reqWdata = 32'hA5A5_A5A5; endianness = ~be;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", reqReady); end
        checks++; if ({rdEn, wrEn} !== 2'b00) begin errors++; $display("[TB] FAIL reset_en: got %b want 00", {rdEn, wrEn}); end
        checks++; if (wrStrobe !== 4'h0) begin errors++; $display("[TB] FAIL reset_strobe: got %h want 0", wrStrobe); end
        checks++; if ({respValid, destEn, misaligned, accessFault} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_resp: got %b want 0000", {respValid, destEn, misaligned, accessFault}); end
        checks++; if (destData !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", destData); end
    endtask

    task automatic test_word_load();
        checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL lw_ready: got %b want 1", reqReady); end
        issue(OP_LW, 32'h100, 32'h0, 1'b0);
        checks++; if ({rdEn, wrEn} !== 2'b10) begin errors++; $display("[TB] FAIL lw_en: got %b want 10", {rdEn, wrEn}); end
        checks++; if (busAddr !== 32'h100) begin errors++; $display("[TB] FAIL lw_addr: got %h want 100", busAddr); end
        checks++; if (respValid !== 1'b0) begin errors++; $display("[TB] FAIL lw_early_resp: got %b want 0", respValid); end
        rdData = 32'hDEAD_BEEF; busWait = 1'b0;
        tick();
        checks++; if ({respValid, destEn, misaligned, accessFault} !== 4'b1100) begin errors++; $display("[TB] FAIL lw_resp: got %b want 1100", {respValid, destEn, misaligned, accessFault}); end
        checks++; if (destData !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lw_data: got %h want deadbeef", destData); end
        checks++; if (rdEn !== 1'b0) begin errors++; $display("[TB] FAIL lw_rd_drop: got %b want 0", rdEn); end
        tick();
        checks++; if ({respValid, reqReady} !== 2'b01) begin errors++; $display("[TB] FAIL lw_back_idle: got %b want 01", {respValid, reqReady}); end
    endtask

    task automatic test_lane_loads();
        issue(OP_LB, 32'h103, 32'h0, 1'b0);
        checks++; if (busAddr !== 32'h100) begin errors++; $display("[TB] FAIL lb_addr: got %h want 100", busAddr); end
        rdData = 32'h8011_2233; busWait = 1'b0;
        tick();
        checks++; if (destData !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_data: got %h want ffffff80", destData); end
        tick();
        issue(OP_LBU, 32'h103, 32'h0, 1'b0);
        tick();
        checks++; if (destData !== 32'h0000_0080) begin errors++; $display("[TB] FAIL lbu_data: got %h want 00000080", destData); end
        tick();
        issue(OP_LH, 32'h102, 32'h0, 1'b1);
        tick();
        checks++; if (destData !== 32'h0000_1180) begin errors++; $display("[TB] FAIL lh_be_data: got %h want 00001180", destData); end
        tick();
        issue(OP_LH, 32'h100, 32'h0, 1'b0);
        rdData = 32'h1234_9ABC;
        tick();
        checks++; if (destData !== 32'hFFFF_9ABC) begin errors++; $display("[TB] FAIL lh_le_data: got %h want ffff9abc", destData); end
        tick();
        issue(OP_LHU, 32'h102, 32'h0, 1'b0);
        tick();
        checks++; if (destData !== 32'h0000_1234) begin errors++; $display("[TB] FAIL lhu_data: got %h want 00001234", destData); end
        tick();
        issue(OP_LW, 32'h100, 32'h0, 1'b1);
        rdData = 32'hDEAD_BEEF;
        tick();
        checks++; if (destData !== 32'hEFBE_ADDE) begin errors++; $display("[TB] FAIL lw_be_data: got %h want efbeadde", destData); end
        tick();
    endtask

    task automatic test_stores();
        issue(OP_SH, 32'h102, 32'h0000_ABCD, 1'b1);
        busWait = 1'b1;
        checks++; if ({rdEn, wrEn} !== 2'b01) begin errors++; $display("[TB] FAIL sh_en: got %b want 01", {rdEn, wrEn}); end
        checks++; if (busAddr !== 32'h100) begin errors++; $display("[TB] FAIL sh_addr: got %h want 100", busAddr); end
        checks++; if (wrData !== 32'hCDAB_0000) begin errors++; $display("[TB] FAIL sh_data: got %h want cdab0000", wrData); end
        checks++; if (wrStrobe !== 4'b1100) begin errors++; $display("[TB] FAIL sh_strobe: got %b want 1100", wrStrobe); end
        tick();
        checks++; if ({wrEn, wrData, wrStrobe} !== {1'b1, 32'hCDAB_0000, 4'b1100}) begin errors++; $display("[TB] FAIL sh_stable: got %b %h %b", wrEn, wrData, wrStrobe); end
        busWait = 1'b0;
        tick();
        checks++; if ({respValid, destEn, destData} !== {2'b10, 32'h0}) begin errors++; $display("[TB] FAIL sh_resp: got %b %b %h want 1 0 0", respValid, destEn, destData); end
        tick();
        issue(OP_SB, 32'h101, 32'h1234_5678, 1'b0);
        checks++; if ({wrData, wrStrobe} !== {32'h0000_7800, 4'b0010}) begin errors++; $display("[TB] FAIL sb_lane: got %h %b want 00007800 0010", wrData, wrStrobe); end
        tick(); tick();
        issue(OP_SW, 32'h104, 32'h1122_3344, 1'b0);
        checks++; if ({busAddr, wrData, wrStrobe} !== {32'h104, 32'h1122_3344, 4'b1111}) begin errors++; $display("[TB] FAIL sw_lane: got %h %h %b", busAddr, wrData, wrStrobe); end
        tick(); tick();
    endtask

    task automatic test_misaligned();
        issue(OP_LW, 32'h101, 32'h0, 1'b0);
        checks++; if ({respValid, misaligned, destEn, accessFault} !== 4'b1100) begin errors++; $display("[TB] FAIL mis_lw_resp: got %b want 1100", {respValid, misaligned, destEn, accessFault}); end
        checks++; if ({rdEn, wrEn} !== 2'b00) begin errors++; $display("[TB] FAIL mis_lw_en: got %b want 00", {rdEn, wrEn}); end
        tick();
        checks++; if ({respValid, misaligned, reqReady} !== 3'b001) begin errors++; $display("[TB] FAIL mis_lw_after: got %b want 001", {respValid, misaligned, reqReady}); end
        issue(OP_SH, 32'h103, 32'h0000_1234, 1'b0);
        checks++; if ({respValid, misaligned, wrEn} !== 3'b110) begin errors++; $display("[TB] FAIL mis_sh: got %b want 110", {respValid, misaligned, wrEn}); end
        tick();
    endtask

    task automatic test_timeout();
        busWait = 1'b1;
        issue(OP_LW, 32'h100, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({rdEn, respValid} !== 2'b10) begin errors++; $display("[TB] FAIL to_wait%0d: got %b want 10", i, {rdEn, respValid}); end
            tick();
        end
        checks++; if ({respValid, accessFault, destEn, rdEn} !== 4'b1100) begin errors++; $display("[TB] FAIL to_resp: got %b want 1100", {respValid, accessFault, destEn, rdEn}); end
        tick();
    endtask

    task automatic test_bus_error();
        busWait = 1'b1; busErr = 1'b1;
        issue(OP_LW, 32'h100, 32'h0, 1'b0);
        tick();
        busErr = 1'b0;
        checks++; if ({respValid, accessFault, destEn} !== 3'b110) begin errors++; $display("[TB] FAIL err_first: got %b want 110", {respValid, accessFault, destEn}); end
        tick();
        issue(OP_LW, 32'h100, 32'h0, 1'b0);
        tick(); tick();
        checks++; if (respValid !== 1'b0) begin errors++; $display("[TB] FAIL err_late_early: got %b want 0", respValid); end
        busErr = 1'b1;
        tick();
        busErr = 1'b0;
        checks++; if ({respValid, accessFault} !== 2'b11) begin errors++; $display("[TB] FAIL err_late: got %b want 11", {respValid, accessFault}); end
        tick();
    endtask

    task automatic test_wait_latency();
        busWait = 1'b1;
        issue(OP_LW, 32'h100, 32'h0, 1'b0);
        tick(); tick(); tick();
        checks++; if ({rdEn, respValid} !== 2'b10) begin errors++; $display("[TB] FAIL wait3_access: got %b want 10", {rdEn, respValid}); end
        busWait = 1'b0; rdData = 32'h1234_5678;
        tick();
        checks++; if ({respValid, accessFault, destEn, destData} !== {3'b101, 32'h1234_5678}) begin errors++; $display("[TB] FAIL wait3_resp: got %b %b %b %h", respValid, accessFault, destEn, destData); end
        tick();
    endtask

    task automatic test_reset_mid();
        busWait = 1'b1;
        issue(OP_SW, 32'h100, 32'h5555_AAAA, 1'b0);
        tick();
        checks++; if (wrEn !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre: got %b want 1", wrEn); end
        rst = 1'b1;
        tick();
        rst = 1'b0; busWait = 1'b0;
        checks++; if ({wrEn, respValid, reqReady} !== 3'b001) begin errors++; $display("[TB] FAIL rstmid_post: got %b want 001", {wrEn, respValid, reqReady}); end
        tick();
        checks++; if ({wrEn, respValid, reqReady} !== 3'b001) begin errors++; $display("[TB] FAIL rstmid_quiet: got %b want 001", {wrEn, respValid, reqReady}); end
    endtask

    task automatic test_nonmem();
        reqValid = 1'b1; reqOp = OP_ALU; reqAddr = 32'h100;
        tick();
        checks++; if ({reqReady, rdEn, wrEn} !== 3'b100) begin errors++; $display("[TB] FAIL nonmem_idle: got %b want 100", {reqReady, rdEn, wrEn}); end
        tick();
        reqValid = 1'b0; reqOp = OP_NOP;
        checks++; if (respValid !== 1'b0) begin errors++; $display("[TB] FAIL nonmem_resp: got %b want 0", respValid); end
    endtask

    task automatic test_back_to_back();
        busWait = 1'b0; rdData = 32'hCAFE_F00D;
        reqValid = 1'b1; reqOp = OP_LW; reqAddr = 32'h100; endianness = 1'b0;
        tick();
        tick();
        checks++; if ({respValid, reqReady, destData} !== {2'b10, 32'hCAFE_F00D}) begin errors++; $display("[TB] FAIL b2b_resp: got %b %b %h", respValid, reqReady, destData); end
        tick();
        checks++; if ({reqReady, rdEn, respValid} !== 3'b100) begin errors++; $display("[TB] FAIL b2b_idle: got %b want 100", {reqReady, rdEn, respValid}); end
        tick();
        reqValid = 1'b0; reqOp = OP_NOP;
        checks++; if ({rdEn, reqReady} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_second: got %b want 10", {rdEn, reqReady}); end
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; reqValid = 1'b0; reqOp = OP_NOP; reqAddr = '0; reqWdata = '0;
        endianness = 1'b0; rdData = '0; busWait = 1'b0; busErr = 1'b0;
        test_reset();
        test_word_load();
        test_lane_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_bus_error();
        test_wait_latency();
        test_reset_mid();
        test_nonmem();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_seq.md
LSU_SEQ -- requirements
Module: lsu_seq

Interface
REQ-001 Parameter XLEN, default 32, DBus data width in bits; legal values are 32 and 64.
REQ-002 Parameter TIMEOUT, default 16, maximum number of consecutive dbus_wait cycles before an access is aborted; legal range is 1 to 255.
REQ-003 clk  in  1  clock; the block SHALL use one clock.
REQ-004 rst  in  1  reset; the reset SHALL be synchronous and active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block is idle and can accept a request.
REQ-007 req_op  in  lsu_op_t  operation; LB, LH, LW, LBU, LHU, SB, SH and SW are memory ops, all other values are non-memory.
REQ-008 req_addr  in  XLEN  byte address.
REQ-009 req_wdata  in  XLEN  store data, with the operand in the low bits.
REQ-010 endianness  in  1  0 = little-endian, 1 = big-endian; the value is sampled at accept.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 dest_en  out  1  register-file write enable; valid only while resp_valid is high.
REQ-013 dest_data  out  XLEN  load result.
REQ-014 misaligned  out  1  misaligned-address exception pulse, coincident with resp_valid.
REQ-015 access_fault  out  1  bus-error or timeout exception pulse, coincident with resp_valid.
REQ-016 DBus ports:
- dbus_rd_en  out  1
- dbus_wr_en  out  1
- dbus_addr  out  XLEN
- dbus_wr_data  out  XLEN
- dbus_wr_strobe  out  XLEN/8
- dbus_rd_data  in  XLEN
- dbus_wait  in  1
- dbus_err  in  1

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP; req_ready SHALL equal (state==IDLE).
REQ-018 A request SHALL be accepted in IDLE when req_valid is high and req_op is a memory op.
- On accept, the block SHALL register op, addr, wdata and endianness.
- Non-memory ops SHALL be ignored; the block stays in IDLE and emits no response.
REQ-019 Misalignment SHALL be defined as: halfword op with addr[0]=1, or word op with addr[1:0]!=0.
- A misaligned accept SHALL go directly to RESP with misaligned=1.
- A misaligned accept SHALL never assert a DBus enable.
REQ-020 A legal accept SHALL go to ACCESS.
- In ACCESS, dbus_rd_en (loads) or dbus_wr_en (stores) SHALL be held high every cycle.
- All DBus outputs SHALL be held stable for the whole of ACCESS.
REQ-021 dbus_addr SHALL equal the registered addr with the low log2(XLEN/8) bits cleared; off = those cleared bits.
REQ-022 The store lane SHALL be placed as follows:
- The operand SHALL be byte-swapped within its access size when the registered endianness is 1.
- The operand SHALL then be shifted left by off*8 bits, with unused lanes driven to 0.
- dbus_wr_strobe SHALL be (1, 3 or F for SB, SH, SW) shifted left by off.
REQ-023 Load extraction SHALL shift dbus_rd_data right by off*8 bits.
- The field SHALL be byte-swapped within its access size when the registered endianness is 1.
- LB and LH SHALL sign-extend the field to XLEN; LBU, LHU and LW SHALL zero-extend it.
REQ-024 In ACCESS, the exit conditions SHALL be evaluated in this order:
- When dbus_err=1, the FSM SHALL go to RESP with access_fault=1; dbus_err SHALL take priority over dbus_wait.
- Otherwise, when dbus_wait=0, the FSM SHALL go to RESP, and load data SHALL be captured into dest_data that cycle.
- Otherwise, the 8-bit wait counter SHALL increment.
- When the counter reaches TIMEOUT, the FSM SHALL go to RESP with access_fault=1, and DBus enables SHALL drop the next cycle.
REQ-025 The wait counter SHALL clear on every accept.
REQ-026 In RESP, the block SHALL assert resp_valid for exactly one cycle, then return to IDLE; a new request SHALL NOT be accepted during RESP.
REQ-027 dest_en SHALL be 1 in RESP only for a load that completed with misaligned=0 and access_fault=0.
REQ-028 dest_data SHALL be 0 whenever dest_en is 0.
REQ-029 Minimum latency SHALL be as follows:
- An accept at edge k, followed by ACCESS in cycle k+1 with dbus_wait=0, SHALL produce resp_valid in cycle k+2.
- Each wait cycle SHALL add one cycle.
- A misaligned request SHALL produce resp_valid in cycle k+1.

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL go to IDLE and the wait counter SHALL clear; the following outputs SHALL then be 0: dbus_rd_en, dbus_wr_en, dbus_wr_strobe, resp_valid, dest_en, dest_data, misaligned and access_fault.
REQ-031 Reset during ACCESS SHALL abandon the transaction with no response; the DBus enables SHALL be low from the edge at which rst is sampled.
REQ-032 After reset, req_ready SHALL be 1.

Verification
REQ-033 Aligned word load: LW addr=0x100, little-endian, dbus_rd_data=0xDEADBEEF, dbus_wait=0 -> dbus_addr=0x100, resp_valid at k+2, dest_en=1, dest_data=0xDEADBEEF.
REQ-034 Byte-lane load, signed and unsigned: LB addr=0x103, dbus_rd_data=0x80112233 -> dest_data=0xFFFFFF80; the same access with LBU -> dest_data=0x00000080.
REQ-035 Big-endian halfword store: SH addr=0x102, endianness=1, wdata=0x0000ABCD -> dbus_addr=0x100, dbus_wr_data=0xCDAB0000, dbus_wr_strobe=4'b1100, dest_en=0.
REQ-036 Misaligned word load: LW addr=0x101 -> no DBus enable asserted, resp_valid and misaligned at k+1, dest_en=0.
REQ-037 Timeout: TIMEOUT=4, LW with dbus_wait held high -> access_fault=1 and dest_en=0 on resp_valid; separately, dbus_err=1 with dbus_wait=1 in the first ACCESS cycle -> access_fault at k+2.
REQ-038 Reset mid-access: rst=1 during the second wait cycle of an SW -> dbus_wr_en=0 on the next cycle, no resp_valid, req_ready=1.
